// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank,
// with a combinational read port that feeds the add-round-key stage.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

module aes_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done,
  output logic         key_valid
);

  typedef enum logic [0:0] {IDLE, EXPAND} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] bank_q [11];
  logic [127:0] bank_d [11];
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         key_valid_q, key_valid_d;

  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  // Previous round key; only meaningful in EXPAND where cnt is 1..10.
  always_comb begin
    prev_idx = cnt_q - 4'd1;
    prev_key = '0;
    if (prev_idx <= 4'd10) prev_key = bank_q[prev_idx];
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*b +: 8]),
      .out_byte (sub_word[8*b +: 8])
    );
  end

  assign t_word    = sub_word ^ {rcon_q, 24'h0};
  assign n0        = prev_key[127:96] ^ t_word;
  assign n1        = prev_key[95:64]  ^ n0;
  assign n2        = prev_key[63:32]  ^ n1;
  assign n3        = prev_key[31:0]   ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    bank_d      = bank_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bank_d[0]   = key_in;
          cnt_d       = 4'd1;
          rcon_d      = 8'h01;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= 10; i++) begin
          if (cnt_q == 4'(i)) bank_d[i] = {n0, n1, n2, n3};
        end
        cnt_d  = cnt_q + 4'd1;
        rcon_d = rcon_next;
        if (cnt_q == 4'd10) begin
          cnt_d       = 4'd0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i < 11; i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      for (int i = 0; i < 11; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Unregistered read so the round key lands in the same cycle it is selected.
  always_comb begin
    round_key = '0;
    if (round_sel <= 4'd10) round_key = bank_q[round_sel];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: word-level key-schedule model with an S-box derived
// from GF(2^8) inversion, checked every cycle, plus FIPS-197 literal vectors.

module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round_sel = '0;
  logic [127:0] round_key;
  logic         busy, done, key_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z = 128'h0;
  localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .round_sel (round_sel),
    .round_key (round_key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // FIPS-197 word recurrence over w[0..43]; returns round key r.
  function automatic logic [127:0] sched_round(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the whole schedule is known at accept; one entry appears per edge.
  logic [127:0] m_bank [11];
  logic [127:0] m_key;
  bit           m_busy, m_done, m_valid;
  int           m_step;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) m_bank[i] = '0;
      m_busy = 0; m_done = 0; m_valid = 0; m_step = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_key = key_in; m_bank[0] = key_in;
          m_busy = 1; m_valid = 0; m_step = 1;
        end
      end else begin
        m_bank[m_step] = sched_round(m_key, m_step);
        if (m_step == 10) begin
          m_busy = 0; m_done = 1; m_valid = 1;
        end
        m_step++;
      end
    end
  end

  always @(negedge clk) begin
    logic [127:0] exp_rk;
    if (chk_en) begin
      exp_rk = (round_sel <= 4'd10) ? m_bank[round_sel] : '0;
      check("cyc_busy", 128'(busy), 128'(m_busy));
      check("cyc_done", 128'(done), 128'(m_done));
      check("cyc_key_valid", 128'(key_valid), 128'(m_valid));
      check("cyc_round_key", round_key, exp_rk);
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input string name, input logic [3:0] sel, input logic [127:0] exp);
    round_sel = sel;
    #1;
    check(name, round_key, exp);
  endtask

  task automatic run_expand(input logic [127:0] k, input string tag);
    int n;
    start = 1'b1; key_in = k;
    tick();
    start = 1'b0;
    check({tag, "_busy_at_accept"}, 128'(busy), 128'd1);
    check({tag, "_valid_drop"}, 128'(key_valid), 128'd0);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd10);
    check({tag, "_valid_rise"}, 128'(key_valid), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int dc;
    build_sbox();
    check("pin_sbox_00", 128'(sbox_m[0]), 128'h63);
    check("pin_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
    check("pin_a_r1", sched_round(KEY_A, 1), A_R1);
    check("pin_a_r10", sched_round(KEY_A, 10), A_R10);
    check("pin_z_r1", sched_round(KEY_Z, 1), Z_R1);
    check("pin_z_r10", sched_round(KEY_Z, 10), Z_R10);

    // Reset held for two edges
    rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_valid", 128'(key_valid), 128'd0);
    for (int s = 0; s < 16; s++) read_key("rst_round_key", 4'(s), 128'h0);
    tick();

    // FIPS-197 A.1
    run_expand(KEY_A, "a1");
    read_key("a1_r1", 4'd1, A_R1);
    read_key("a1_r10", 4'd10, A_R10);
    read_key("a1_r0", 4'd0, KEY_A);
    tick();
    check("a1_done_pulse", 128'(done), 128'd0);

    // All-zero key, also a back-to-back restart over a valid schedule
    round_sel = 4'd10;
    run_expand(KEY_Z, "zero");
    read_key("zero_r1", 4'd1, Z_R1);
    read_key("zero_r10", 4'd10, Z_R10);

    // start during EXPAND must be ignored
    start = 1'b1; key_in = KEY_A;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (n == 4) begin start = 1'b1; key_in = KEY_Z; end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    check("ign_latency", 128'(n), 128'd10);
    read_key("ign_r10", 4'd10, A_R10);
    read_key("ign_r0", 4'd0, KEY_A);

    // Reset mid-expansion
    tick();
    dc = done_cnt;
    start = 1'b1; key_in = KEY_A;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_valid", 128'(key_valid), 128'd0);
    read_key("midrst_r0", 4'd0, 128'h0);
    for (int i = 0; i < 14; i++) tick();
    check("midrst_no_done", 128'(done_cnt), 128'(dc));
    check("midrst_valid_hold", 128'(key_valid), 128'd0);
    run_expand(KEY_A, "restart");
    read_key("restart_r1", 4'd1, A_R1);
    read_key("restart_r10", 4'd10, A_R10);

    // start and rst on the same edge
    tick();
    rst = 1'b1; start = 1'b1; key_in = KEY_Z;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", 128'(busy), 128'd0);
    tick();
    check("rst_wins_idle", 128'(busy), 128'd0);

    // Back-to-back: A.1 then zero key immediately after done
    run_expand(KEY_A, "b2b_a");
    round_sel = 4'd10;
    run_expand(KEY_Z, "b2b_z");
    read_key("b2b_r10", 4'd10, Z_R10);
    read_key("b2b_sel11", 4'd11, 128'h0);
    check("b2b_valid", 128'(key_valid), 128'd1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Iterative AES-128 key schedule. Expands a 128-bit cipher key into the eleven round keys (rounds 0–10), producing one key per clock, and holds them in an internal register bank. The bank is read by round index and supplies the `key` operand of the add-round-key stage directly upstream of it in the encrypt/decrypt datapath. Byte order follows FIPS-197 big-endian: word w0 = bits [127:96], byte 0 = bits [127:120].

## Interface
- No parameters. AES-128 only.
- `clk` in 1 — system clock, rising-edge.
- `rst` in 1 — reset, synchronous, active-high.
- `start` in 1 — request expansion of `key_in`; sampled only in IDLE.
- `key_in` in 128 — cipher key; sampled on the edge that accepts `start`.
- `round_sel` in 4 — round index 0–10 to read.
- `round_key` out 128 — combinational read of bank[`round_sel`]; 0 when `round_sel` > 10.
- `busy` out 1 — high while in EXPAND.
- `done` out 1 — one-cycle pulse when round key 10 has been written.
- `key_valid` out 1 — level; all 11 bank entries hold the current key's schedule.

## Operation
- States: IDLE, EXPAND.
- IDLE with `start`=1:
  - bank[0] <= `key_in`.
  - cnt <= 1.
  - rcon <= 8'h01.
  - `key_valid` <= 0.
  - Next state EXPAND.
- IDLE with `start`=0: hold everything.
- EXPAND, each cycle, with prev = bank[cnt-1] split into words p0..p3:
  - t = SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - RotWord(w) = {w[23:0], w[31:24]}.
  - SubWord applies the AES forward S-box to each byte. The S-box is an internal combinational LUT, 4 instances.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - bank[cnt] <= {n0, n1, n2, n3}.
  - cnt <= cnt+1.
  - rcon <= xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- EXPAND with cnt == 10: write bank[10], then next state IDLE, `done` <= 1, `key_valid` <= 1.
- `start` while in EXPAND is ignored; it is not queued.
- `start` in IDLE while `key_valid`=1 starts a new expansion:
  - `key_valid` falls on that edge.
  - Old bank[1..10] contents remain readable but are stale until `done`.
- Bank registers have no enable other than the write above. Each entry is written only once per expansion.
- Reads use `round_sel` at any time; the consumer reads only when `key_valid`=1.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State IDLE, cnt=0, rcon=01.
  - All bank entries 0.
  - `busy`=0, `done`=0, `key_valid`=0, `round_key`=0.
- Edge E0 samples `start`: bank[0] written; `busy`=1 from E0.
- Edges E1..E10 write bank[1]..bank[10]. A new round key is visible on `round_key` (if selected) in the cycle after its write edge.
- After E10: `busy`=0, `done`=1 for exactly one cycle, `key_valid`=1.
- Latency: `start` sample to `done` high = 10 cycles after E0. Accept-to-accept minimum spacing = 11 cycles.
- `rst` asserted mid-EXPAND: the next edge returns to the reset values above. No partial `done`. `key_valid` stays 0.
- `start` and `rst` on the same edge: `rst` wins.
- `round_key` is purely combinational from the bank and `round_sel`; it carries no register stage.

## Test plan
- Reset: hold `rst` 2 cycles → `busy`=0, `done`=0, `key_valid`=0, `round_key`=0 for every `round_sel` 0–15.
- FIPS-197 A.1, `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start` → `done` 10 cycles after the accept edge, then:
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round 0 = `key_in`.
- All-zero key → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Pulse `start` again with a different key at cycle 4 of EXPAND → ignored. The schedule completes for the first key with `done` at the original cycle.
- Assert `rst` at cycle 6 of EXPAND → `key_valid` stays 0, no `done`. A restart with the A.1 key yields correct keys.
- Back-to-back: after A.1 completes, `start` with the zero key → `key_valid` drops on the accept edge and returns with `done`. Round 10 reads b4ef5bcb3e92e21123e951cf6f8f188e. `round_sel`=11 reads 0.
